ysyx_22041461_mem_arbiter: RTL
==============================

# ysyx_22041461_mem_arbiter

Two-requester arbiter that shares the single memory port between instruction fetch (IFU) and load/store (LSU) once the core moves to multi-cycle memory. Each side uses a valid/ready request handshake and gets a single-cycle response pulse. The arbiter grants one transaction at a time and registers the winning request. It round-robins on contention, watches each transaction with a timeout counter, and routes the memory response back to the owner.

## Interface
- `TIMEOUT`, default 255: cycles a transaction may spend in REQ+RESP before being aborted with error; must be ≥ 2.
- `clk` in 1: the only clock; everything samples on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ifu_req_valid` in 1, `ifu_req_ready` out 1, `ifu_addr` in 64: IFU read request; IFU never writes.
- `ifu_resp_valid` out 1, `ifu_rdata` out 64, `ifu_resp_err` out 1: IFU response.
- `lsu_req_valid` in 1, `lsu_req_ready` out 1, `lsu_addr` in 64, `lsu_wen` in 1, `lsu_wdata` in 64, `lsu_wmask` in 8: LSU request.
- `lsu_resp_valid` out 1, `lsu_rdata` out 64, `lsu_resp_err` out 1: LSU response; a write also returns a response.
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_addr` out 64, `mem_wen` out 1, `mem_wdata` out 64, `mem_wmask` out 8: memory request.
- `mem_resp_valid` in 1, `mem_rdata` in 64: memory response, one pulse per accepted request.

## Operation
- **FSM states:** IDLE, REQ, RESP. A 1-bit `owner` register records the active requester (0=IFU, 1=LSU). A 1-bit `last` register records the last granted requester.
- **IDLE:**
  - Exactly one `*_req_ready` is high, chosen combinationally from the valids.
  - If only one requester is valid, that one gets ready.
  - If both are valid, the side not equal to `last` gets ready.
  - If neither is valid, LSU gets ready.
  - On `valid && ready`: capture addr/wen/wdata/wmask into the request register, set `owner` and `last`, clear the timer, go to REQ.
  - For an IFU capture, wen=0, wdata=0, wmask=0xFF.
- **REQ:**
  - `mem_req_valid`=1 and the mem_* outputs are driven from the request register; they stay stable until accepted.
  - On `mem_req_ready`: go to RESP.
- **RESP:**
  - `mem_req_valid`=0.
  - On `mem_resp_valid`: the owner's `resp_valid`=1 in the same cycle, `rdata`=`mem_rdata` (combinational pass-through), `resp_err`=0. Next state is IDLE.
- **Timer:** 8+ bit counter. It increments every cycle in REQ or RESP and is cleared in IDLE.
  - If the timer reaches `TIMEOUT-1` without completion, the owner gets `resp_valid`=1, `resp_err`=1, `rdata`=0 that cycle. Next state is IDLE.
  - If the timeout cycle coincides with `mem_resp_valid`, the normal response wins and `resp_err`=0.
- **Non-owner side:** `resp_valid`=0 and `rdata`=0 at all times.
- **Outside IDLE:** both `req_ready`=0.
- **Stale responses:** `mem_resp_valid` in IDLE or REQ is ignored (the stale response after a timeout). The memory side must not respond to an aborted request once a new one has been issued.

## Timing
- **Reset values:** state=IDLE, owner=0, last=0 (IFU), timer=0, request register=0. All resp_valid/err=0, mem_req_valid=0, mem_wen=0. rdata outputs are 0.
- **Effect of `last`=0 after reset:** the first contended grant goes to LSU.
- **Best-case latency:**
  - Handshake at cycle T, `mem_req_valid` at T+1.
  - With `mem_req_ready` at T+1 and `mem_resp_valid` at T+2, the requester sees `resp_valid` at T+2.
  - Next `req_ready` is at T+3.
  - Throughput is therefore one transaction per 3 cycles minimum.
- **Back-pressure:** `mem_req_ready` low holds REQ with the outputs unchanged, while the timer runs.
- **Reset mid-transaction:** the next cycle is IDLE with all outputs at reset values. The in-flight transaction is dropped, with no response to the requester.
- **Request stability:** requesters may drop or change `req_valid` while not ready. The arbiter samples only at the handshake.

## Test plan
- **Single IFU read:** reset, then IFU valid with addr=0x8000_0000. Mem ready at once and responds rdata=0x0000_0013_0000_0093 one cycle later. Expect: `mem_addr`=0x8000_0000, `mem_wmask`=0xFF, `mem_wen`=0, `ifu_resp_valid` pulse carrying that data 2 cycles after the handshake, LSU outputs idle.
- **LSU write:** addr=0x8000_1008, wdata=0xDEAD_BEEF_0000_0001, wmask=0x0F, mem ready delayed 3 cycles. Expect: mem_* held stable for 4 cycles, `lsu_resp_valid` with err=0 after `mem_resp_valid`.
- **Contention:** both valid continuously for 4 transactions from reset. Expect grant order LSU, IFU, LSU, IFU, and at most one `req_ready` high per cycle.
- **Timeout:** TIMEOUT=8, LSU read, mem never responds. Expect `lsu_resp_valid`=1 with `lsu_resp_err`=1 and rdata=0 on the 8th cycle after the handshake, then IDLE; a later stale `mem_resp_valid` in IDLE produces no response.
- **Timeout boundary:** `mem_resp_valid` on exactly the timeout cycle. Expect a normal response with err=0 and the data passed through.
- **Reset mid-operation:** assert `rst` in RESP. Expect all outputs at reset values next cycle, no `resp_valid`, and a following IFU request served normally.

Source files
------------

// File: rtl/ysyx_22041461_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for a single multi-cycle memory port.
// Round-robin on contention, one transaction in flight, timeout abort with error.
module ysyx_22041461_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [63:0] ifu_rdata,
    output logic        ifu_resp_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_rdata,
    output logic        lsu_resp_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_rdata
);

    localparam int TW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t      state, state_next;
    logic        owner;
    logic        last;
    logic [TW-1:0] timer;

    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;

    logic        grant_lsu;
    logic        accept;
    logic        busy;
    logic        mem_done;
    logic        timed_out;
    logic        finish;
    logic [63:0] resp_data;

    // Contention goes to the side that was not granted last.
    always_comb begin
        grant_lsu = 1'b1;
        case ({ifu_req_valid, lsu_req_valid})
            2'b10:   grant_lsu = 1'b0;
            2'b01:   grant_lsu = 1'b1;
            2'b11:   grant_lsu = ~last;
            default: grant_lsu = 1'b1;
        endcase
    end

    assign ifu_req_ready = (state == IDLE) && !grant_lsu;
    assign lsu_req_ready = (state == IDLE) && grant_lsu;
    assign accept        = (state == IDLE) && (grant_lsu ? lsu_req_valid : ifu_req_valid);

    assign busy      = (state != IDLE);
    assign mem_done  = (state == RESP) && mem_resp_valid;
    // A real response arriving on the timeout cycle takes priority over the abort.
    assign timed_out = busy && (timer == TW'(TIMEOUT - 1)) && !mem_done;
    assign finish    = mem_done || timed_out;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = REQ;
            REQ: begin
                if (timed_out)          state_next = IDLE;
                else if (mem_req_ready) state_next = RESP;
            end
            RESP: if (finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b0;
            timer     <= '0;
            req_addr  <= '0;
            req_wen   <= 1'b0;
            req_wdata <= '0;
            req_wmask <= '0;
        end else begin
            state <= state_next;
            timer <= busy ? timer + TW'(1) : '0;
            if (accept) begin
                owner <= grant_lsu;
                last  <= grant_lsu;
                if (grant_lsu) begin
                    req_addr  <= lsu_addr;
                    req_wen   <= lsu_wen;
                    req_wdata <= lsu_wdata;
                    req_wmask <= lsu_wmask;
                end else begin
                    req_addr  <= ifu_addr;
                    req_wen   <= 1'b0;
                    req_wdata <= '0;
                    req_wmask <= 8'hFF;
                end
            end
        end
    end

    assign mem_req_valid = (state == REQ);
    assign mem_addr      = req_addr;
    assign mem_wen       = req_wen;
    assign mem_wdata     = req_wdata;
    assign mem_wmask     = req_wmask;

    assign resp_data = mem_done ? mem_rdata : '0;

    assign ifu_resp_valid = finish && !owner;
    assign ifu_resp_err   = timed_out && !owner;
    assign ifu_rdata      = (finish && !owner) ? resp_data : '0;

    assign lsu_resp_valid = finish && owner;
    assign lsu_resp_err   = timed_out && owner;
    assign lsu_rdata      = (finish && owner) ? resp_data : '0;

endmodule
